cache_flush_seq: RTL and testbench

Sequencer for the cache's flush / invalidate-all operation. Walks every index of the 4-way tag, valid, dirty and data arrays. Writes back each valid+dirty line to main memory, then clears valid, dirty and LRU state for the index. Arbitrates for the arrays with the main cache FSM through a req/gnt pair and runs only while granted.

---
 rtl/cache_flush_seq_if.sv | 33 +++
 rtl/cache_flush_seq.sv | 119 +++++++++++
 tb/tb_cache_flush_seq.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_flush_seq_if.sv
// Array and write-back port bundle between the flush sequencer (master) and the
// cache arrays / memory side (slave).
interface cache_flush_seq_if #(
   parameter int IDX_W  = 13,
   parameter int TAG_W  = 14,
   parameter int LINE_W = 256
);
   logic                     flush_req;
   logic                     flush_gnt;
   logic                     meta_rd;
   logic [IDX_W-1:0]         idx;
   logic [3:0]               val_in;
   logic [3:0]               mod_in;
   logic [4*TAG_W-1:0]       tag_in;
   logic                     data_rd;
   logic [1:0]               way_sel;
   logic [LINE_W-1:0]        data_in;
   logic                     wb_req;
   logic [TAG_W+IDX_W-1:0]   wb_addr;
   logic [LINE_W-1:0]        wb_data;
   logic                     wb_ack;
   logic                     clr_en;

   modport master (
      output flush_req, meta_rd, idx, data_rd, way_sel, wb_req, wb_addr, wb_data, clr_en,
      input  flush_gnt, val_in, mod_in, tag_in, data_in, wb_ack
   );

   modport slave (
      input  flush_req, meta_rd, idx, data_rd, way_sel, wb_req, wb_addr, wb_data, clr_en,
      output flush_gnt, val_in, mod_in, tag_in, data_in, wb_ack
   );
endinterface

// File: rtl/cache_flush_seq.sv
// Flush / invalidate-all sequencer: walks every set, writes back valid+dirty ways in way order, then clears the set.
// Clean set costs 4 cycles, each dirty way 3 + ack wait; stalls in REQ until flush_gnt and in WB until wb_ack.
module cache_flush_seq #(
   parameter int IDX_W  = 13,
   parameter int TAG_W  = 14,
   parameter int LINE_W = 256,
   parameter int WAYS   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        mode,
   output logic        busy,
   output logic        done,
   output logic [15:0] wb_count,
   cache_flush_seq_if.master arr
);
   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_REQ  = 4'd1;
   localparam logic [3:0] S_META = 4'd2;
   localparam logic [3:0] S_CAPT = 4'd3;
   localparam logic [3:0] S_SCAN = 4'd4;
   localparam logic [3:0] S_DRD  = 4'd5;
   localparam logic [3:0] S_DCAP = 4'd6;
   localparam logic [3:0] S_WB   = 4'd7;
   localparam logic [3:0] S_CLR  = 4'd8;
   localparam logic [3:0] S_DONE = 4'd9;

   logic [3:0]            state;
   logic                  mode_q;
   logic [IDX_W-1:0]      idx;
   logic [WAYS-1:0]       pending;
   logic [WAYS*TAG_W-1:0] tags;
   logic [1:0]            way_sel;
   logic [1:0]            first_way;
   logic [LINE_W-1:0]     wb_data;

   // Lowest pending way wins so write-backs leave in ascending way order.
   always_comb begin
      first_way = 2'd0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (pending[w]) first_way = w[1:0];
      end
   end

   assign busy          = (state != S_IDLE);
   assign done          = (state == S_DONE);
   assign arr.flush_req = (state != S_IDLE);
   assign arr.meta_rd   = (state == S_META);
   assign arr.data_rd   = (state == S_DRD);
   assign arr.wb_req    = (state == S_WB);
   assign arr.clr_en    = (state == S_CLR);
   assign arr.idx       = idx;
   assign arr.way_sel   = way_sel;
   assign arr.wb_data   = wb_data;
   assign arr.wb_addr   = (state == S_WB) ? {tags[int'(way_sel)*TAG_W +: TAG_W], idx} : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         mode_q   <= 1'b0;
         idx      <= '0;
         pending  <= '0;
         tags     <= '0;
         way_sel  <= 2'd0;
         wb_data  <= '0;
         wb_count <= 16'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q   <= mode;
                  idx      <= '0;
                  wb_count <= 16'd0;
                  state    <= S_REQ;
               end
            end
            S_REQ:  if (arr.flush_gnt) state <= S_META;
            S_META: state <= S_CAPT;
            S_CAPT: begin
               // Invalidate-only mode discards dirty data, so nothing is queued for write-back.
               pending <= mode_q ? '0 : (arr.val_in & arr.mod_in);
               tags    <= arr.tag_in;
               state   <= S_SCAN;
            end
            S_SCAN: begin
               if (|pending) begin
                  way_sel <= first_way;
                  state   <= S_DRD;
               end else begin
                  state   <= S_CLR;
               end
            end
            S_DRD:  state <= S_DCAP;
            S_DCAP: begin
               wb_data <= arr.data_in;
               state   <= S_WB;
            end
            S_WB: begin
               if (arr.wb_ack) begin
                  pending[way_sel] <= 1'b0;
                  if (wb_count != 16'hFFFF) wb_count <= wb_count + 16'd1;
                  state <= S_SCAN;
               end
            end
            S_CLR: begin
               if (idx == {IDX_W{1'b1}}) begin
                  state <= S_DONE;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= S_META;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_flush_seq.sv
// Bench for cache_flush_seq: array/memory responder, scoreboard built from a set/way model, directed and random flushes.
module tb_cache_flush_seq;
   localparam int IDX_W  = 3;
   localparam int TAG_W  = 14;
   localparam int LINE_W = 256;
   localparam int NSETS  = 1 << IDX_W;
   localparam int W      = LINE_W;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] wb_count;

   cache_flush_seq_if #(.IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) bus ();

   cache_flush_seq #(.IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W), .WAYS(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .busy     (busy),
      .done     (done),
      .wb_count (wb_count),
      .arr      (bus)
   );

   initial forever #5 clk = ~clk;

   // Cache contents model
   logic [3:0]        val_m  [NSETS];
   logic [3:0]        mod_m  [NSETS];
   logic [TAG_W-1:0]  tag_m  [NSETS][4];
   logic [LINE_W-1:0] data_m [NSETS][4];

   logic [TAG_W+IDX_W-1:0] exp_addr [$];
   logic [LINE_W-1:0]      exp_data [$];
   int                     exp_clr  [$];
   int                     delay_q  [$];
   int                     k_q      [$];

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int gnt_cyc  = 0;
   int done_cnt = 0;
   int extra    = 0;
   bit gnt_seen = 1'b0;
   bit ack_noise = 1'b0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   // Array / memory responder: read data one cycle after the strobe, grant 2 cycles after request, programmable ack wait.
   initial begin : responder
      logic m, d;
      logic [1:0] ws;
      logic [IDX_W-1:0] ix;
      int wait_cnt, cur_delay, req_cnt;
      bus.flush_gnt = 1'b0; bus.val_in = '0; bus.mod_in = '0; bus.tag_in = '0;
      bus.data_in = '0; bus.wb_ack = 1'b0;
      wait_cnt = 0; cur_delay = 0; req_cnt = 0;
      forever begin
         @(negedge clk);
         m = bus.meta_rd; d = bus.data_rd; ws = bus.way_sel; ix = bus.idx;
         @(posedge clk);
         #1;
         if (m) begin
            bus.val_in = val_m[ix];
            bus.mod_in = mod_m[ix];
            for (int w = 0; w < 4; w++) bus.tag_in[w*TAG_W +: TAG_W] = tag_m[ix][w];
         end
         if (d) bus.data_in = data_m[ix][ws];
         if (bus.flush_req) req_cnt++; else req_cnt = 0;
         bus.flush_gnt = (req_cnt >= 3);
         if (bus.wb_req) begin
            if (wait_cnt == 0) cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : int'($urandom_range(0, 3));
            if (wait_cnt == cur_delay) begin
               bus.wb_ack = 1'b1;
               extra += cur_delay + 4;
               wait_cnt = 0;
            end else begin
               bus.wb_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
            bus.wb_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
   end

   // Scoreboard: write-back order/content, stability while waiting, clear order, strobe exclusivity.
   initial begin : monitor
      logic prev_wait;
      logic [TAG_W+IDX_W-1:0] prev_addr;
      logic [LINE_W-1:0] prev_data;
      int wb_k;
      prev_wait = 1'b0; prev_addr = '0; prev_data = '0; wb_k = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_wait = 1'b0;
            wb_k = 0;
            continue;
         end
         if (bus.meta_rd | bus.data_rd | bus.clr_en | bus.wb_req)
            check("strobe_excl", W'($countones({bus.meta_rd, bus.data_rd, bus.clr_en, bus.wb_req})), W'(1));
         if (bus.flush_req && bus.flush_gnt && !gnt_seen) begin
            gnt_seen = 1'b1;
            gnt_cyc = cyc;
         end
         if (done) done_cnt++;
         if (bus.wb_req) begin
            wb_k++;
            if (prev_wait) begin
               check("wb_addr_stable", W'(bus.wb_addr), W'(prev_addr));
               check("wb_data_stable", bus.wb_data, prev_data);
            end
            if (bus.wb_ack) begin
               check("wb_expected", W'(exp_addr.size() > 0), W'(1));
               if (exp_addr.size() > 0) begin
                  check("wb_addr", W'(bus.wb_addr), W'(exp_addr.pop_front()));
                  check("wb_data", bus.wb_data, exp_data.pop_front());
               end
               k_q.push_back(wb_k);
               wb_k = 0;
               prev_wait = 1'b0;
            end else begin
               prev_wait = 1'b1;
               prev_addr = bus.wb_addr;
               prev_data = bus.wb_data;
            end
         end
         if (bus.clr_en) begin
            check("clr_expected", W'(exp_clr.size() > 0), W'(1));
            if (exp_clr.size() > 0) check("clr_idx", W'(bus.idx), W'(exp_clr.pop_front()));
            if (exp_addr.size() > 0) check("wb_before_clr", W'(exp_addr[0][IDX_W-1:0] != bus.idx), W'(1));
         end
      end
   end

   task automatic clear_model();
      for (int i = 0; i < NSETS; i++) begin
         val_m[i] = '0;
         mod_m[i] = '0;
         for (int w = 0; w < 4; w++) begin
            tag_m[i][w]  = '0;
            data_m[i][w] = '0;
         end
      end
   endtask

   task automatic random_model();
      for (int i = 0; i < NSETS; i++) begin
         val_m[i] = 4'($urandom);
         mod_m[i] = 4'($urandom);
         for (int w = 0; w < 4; w++) begin
            tag_m[i][w] = TAG_W'($urandom);
            for (int j = 0; j < LINE_W / 32; j++) data_m[i][w][j*32 +: 32] = $urandom;
         end
      end
   endtask

   // Expected transactions: every valid+dirty way (clean+invalidate only), set by set, way by way; one clear per set.
   task automatic build_exp(input logic m);
      exp_addr.delete(); exp_data.delete(); exp_clr.delete(); k_q.delete();
      for (int i = 0; i < NSETS; i++) begin
         for (int w = 0; w < 4; w++) begin
            if (!m && val_m[i][w] && mod_m[i][w]) begin
               exp_addr.push_back({tag_m[i][w], IDX_W'(i)});
               exp_data.push_back(data_m[i][w]);
            end
         end
         exp_clr.push_back(i);
      end
   endtask

   task automatic check_zero(input string p);
      check({p, "_busy"},      W'(busy),          '0);
      check({p, "_done"},      W'(done),          '0);
      check({p, "_flush_req"}, W'(bus.flush_req), '0);
      check({p, "_meta_rd"},   W'(bus.meta_rd),   '0);
      check({p, "_data_rd"},   W'(bus.data_rd),   '0);
      check({p, "_clr_en"},    W'(bus.clr_en),    '0);
      check({p, "_wb_req"},    W'(bus.wb_req),    '0);
      check({p, "_idx"},       W'(bus.idx),       '0);
      check({p, "_way_sel"},   W'(bus.way_sel),   '0);
      check({p, "_wb_addr"},   W'(bus.wb_addr),   '0);
      check({p, "_wb_data"},   bus.wb_data,       '0);
      check({p, "_wb_count"},  W'(wb_count),      '0);
   endtask

   task automatic run_flush(input string p, input logic m, input bit poke);
      int n_wb;
      bit timeout;
      build_exp(m);
      n_wb = exp_addr.size();
      gnt_seen = 1'b0; done_cnt = 0; extra = 0;
      @(negedge clk); start = 1'b1; mode = m;
      @(negedge clk); start = 1'b0; mode = ~m;
      check({p, "_busy_start"}, W'(busy), W'(1));
      check({p, "_req_start"},  W'(bus.flush_req), W'(1));
      timeout = 1'b1;
      for (int t = 0; t < 4000; t++) begin
         @(negedge clk);
         start = (poke && t == 12);
         if (done) begin
            timeout = 1'b0;
            break;
         end
      end
      start = 1'b0;
      check({p, "_timeout"}, W'(timeout), '0);
      check({p, "_done_latency"}, W'(cyc - gnt_cyc), W'(33 + extra));
      @(negedge clk);
      check({p, "_busy_after"}, W'(busy), '0);
      check({p, "_req_after"},  W'(bus.flush_req), '0);
      check({p, "_done_pulse"}, W'(done), '0);
      check({p, "_wb_count"},   W'(wb_count), W'(n_wb));
      repeat (3) @(negedge clk);
      check({p, "_done_count"}, W'(done_cnt), W'(1));
      check({p, "_wb_left"},    W'(exp_addr.size()), '0);
      check({p, "_clr_left"},   W'(exp_clr.size()), '0);
   endtask

   initial begin : main
      bit timeout;
      clear_model();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("rst");
      reset = 1'b0;

      run_flush("empty", 1'b0, 1'b0);

      clear_model();
      val_m[2][1] = 1'b1; mod_m[2][1] = 1'b1;
      tag_m[2][1] = 14'h155; data_m[2][1] = {8{32'hA5A5A5A5}};
      val_m[4][3] = 1'b1; tag_m[4][3] = 14'h3FF;
      mod_m[6][0] = 1'b1; tag_m[6][0] = 14'h2AA;
      run_flush("single", 1'b0, 1'b0);

      clear_model();
      val_m[0] = 4'hF; mod_m[0] = 4'hF;
      for (int w = 0; w < 4; w++) begin
         tag_m[0][w]  = TAG_W'(w + 1);
         data_m[0][w] = {8{32'h1111_0000 + 32'(w)}};
      end
      run_flush("four", 1'b0, 1'b0);
      check("four_writes", W'(k_q.size()), W'(4));
      run_flush("inval", 1'b1, 1'b0);

      clear_model();
      val_m[1] = 4'b1001; mod_m[1] = 4'b1001;
      tag_m[1][0] = 14'h0AB; tag_m[1][3] = 14'h1CD;
      data_m[1][0] = {8{32'hDEADBEEF}}; data_m[1][3] = {8{32'hCAFEF00D}};
      delay_q.push_back(5); delay_q.push_back(0);
      run_flush("delay", 1'b0, 1'b0);
      check("delay_k_count", W'(k_q.size()), W'(2));
      if (k_q.size() == 2) begin
         check("delay_k0", W'(k_q[0]), W'(6));
         check("delay_k1", W'(k_q[1]), W'(1));
      end

      ack_noise = 1'b1;
      random_model();
      run_flush("busy_start", 1'b0, 1'b1);
      for (int r = 0; r < 3; r++) begin
         random_model();
         run_flush($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b0);
      end
      ack_noise = 1'b0;

      clear_model();
      val_m[3][0] = 1'b1; mod_m[3][0] = 1'b1; tag_m[3][0] = 14'h033; data_m[3][0] = {8{32'h33333333}};
      val_m[5][2] = 1'b1; mod_m[5][2] = 1'b1; tag_m[5][2] = 14'h255; data_m[5][2] = {8{32'h55555555}};
      delay_q.delete();
      delay_q.push_back(0); delay_q.push_back(20);
      build_exp(1'b0);
      gnt_seen = 1'b0;
      @(negedge clk); start = 1'b1; mode = 1'b0;
      @(negedge clk); start = 1'b0;
      timeout = 1'b1;
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         if (bus.wb_req && bus.idx == IDX_W'(5)) begin
            timeout = 1'b0;
            break;
         end
      end
      check("rst_wb_timeout", W'(timeout), '0);
      check("rst_wb_count_pre", W'(wb_count), W'(1));
      reset = 1'b1;
      @(negedge clk);
      check_zero("rst_mid");
      reset = 1'b0;
      delay_q.delete();
      run_flush("after_rst", 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
